// File: rtl/edge_window_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : edge_window_scheduler_if                                          |
// | Desc   : Pixel-in / window-out / edge-map bundle of edge_window_scheduler. |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface edge_window_scheduler_if;
    logic         start;
    logic [23:0]  pix_in;
    logic         pix_valid;
    logic         pix_ready;
    logic [215:0] win;
    logic         ed_en;
    logic         ed_out;
    logic         edge_out;
    logic         edge_valid;
    logic         busy;
    logic         done;

    modport master (
        output start, pix_in, pix_valid, ed_out,
        input  pix_ready, win, ed_en, edge_out, edge_valid, busy, done
    );

    modport slave (
        input  start, pix_in, pix_valid, ed_out,
        output pix_ready, win, ed_en, edge_out, edge_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/edge_window_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : edge_window_scheduler                                             |
// | Desc   : Builds 3x3 RGB windows from a raster stream, drives the edge      |
// |          detector and emits one edge bit per interior pixel.               |
// |          EDGE_SCHED_STATS_EN adds a saturating edge_count output.          |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module edge_window_scheduler #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  wire                   clk,
    input  wire                   rst_n,
    edge_window_scheduler_if.slave bus
`ifdef EDGE_SCHED_STATS_EN
    ,
    output logic [15:0]           edge_count
`endif
);

    localparam int c_COL_W = $clog2(IMG_W);
    localparam int c_ROW_W = $clog2(IMG_H);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_H - 1);
    localparam logic [c_COL_W-1:0] c_COL_TWO  = c_COL_W'(2);
    localparam logic [c_ROW_W-1:0] c_ROW_TWO  = c_ROW_W'(2);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic [23:0]        r_lb0 [IMG_W];
    logic [23:0]        r_lb1 [IMG_W];
    logic [71:0]        r_wcol_l;
    logic [71:0]        r_wcol_m;
    logic [215:0]       r_win;
    logic               r_ed_en;
    logic               r_edge_out;
    logic               r_edge_valid;

    logic               w_pix_ready;
    logic               w_busy;
    logic               w_done;
    logic               w_start_ok;
    logic               w_accept;
    logic               w_complete;
    logic               w_last_pix;
    logic [71:0]        w_new_col;
    logic [215:0]       w_win_nxt;

    assign w_last_pix = (r_col == c_COL_LAST) && (r_row == c_ROW_LAST);
    assign w_accept   = bus.pix_valid && w_pix_ready;
    assign w_complete = w_accept && (r_row >= c_ROW_TWO) && (r_col >= c_COL_TWO);

    // Column vectors are {top, mid, bottom}; the window is reassembled row-major.
    assign w_new_col = {r_lb1[r_col], r_lb0[r_col], bus.pix_in};
    assign w_win_nxt = {r_wcol_l[71:48], r_wcol_m[71:48], w_new_col[71:48],
                        r_wcol_l[47:24], r_wcol_m[47:24], w_new_col[47:24],
                        r_wcol_l[23:0],  r_wcol_m[23:0],  w_new_col[23:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // In DRAIN the only pending window is the last one, so a result with no
    // detector request behind it is the final result of the frame.
    always_comb begin
        w_state_nxt = r_state;
        w_pix_ready = 1'b0;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        w_start_ok  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                w_pix_ready = 1'b1;
                if (bus.pix_valid && w_last_pix) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (r_edge_valid && r_ed_en) begin
                    w_done      = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col        <= '0;
            r_row        <= '0;
            r_wcol_l     <= '0;
            r_wcol_m     <= '0;
            r_win        <= '0;
            r_ed_en      <= 1'b1;
            r_edge_out   <= 1'b0;
            r_edge_valid <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_accept) begin
                if (r_col == c_COL_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            if (w_accept) begin
                r_wcol_l <= r_wcol_m;
                r_wcol_m <= w_new_col;
            end
            if (w_complete) begin
                r_win <= w_win_nxt;
            end
            r_ed_en      <= ~w_complete;
            r_edge_valid <= ~r_ed_en;
            if (!r_ed_en) begin
                r_edge_out <= bus.ed_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[r_col] <= r_lb0[r_col];
            r_lb0[r_col] <= bus.pix_in;
        end
    end

`ifdef EDGE_SCHED_STATS_EN
    logic [15:0] r_edge_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edge_count <= '0;
        end else if (w_start_ok) begin
            r_edge_count <= '0;
        end else if (r_edge_valid && r_edge_out && (r_edge_count != 16'hFFFF)) begin
            r_edge_count <= r_edge_count + 16'd1;
        end
    end

    assign edge_count = r_edge_count;
`endif

    assign bus.pix_ready  = w_pix_ready;
    assign bus.win        = r_win;
    assign bus.ed_en      = r_ed_en;
    assign bus.edge_out   = r_edge_out;
    assign bus.edge_valid = r_edge_valid;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;

endmodule
`default_nettype wire

// File: doc/edge_window_scheduler.md
# edge_window_scheduler

Sequences the three-channel edge detector over a raster-scan RGB frame. Accepts one 24-bit pixel per cycle and keeps two line buffers to assemble the 3x3 neighbourhood. For each interior pixel it presents the window to `three`-channel edge detection, pulses the detector's active-low enable, and captures the result bit into an edge-map output stream. It sits between the frame pixel source and the haze-removal stages that consume the edge map.

## Interface
- `IMG_W`, 64, frame width in pixels (≥3)
- `IMG_H`, 64, frame height in pixels (≥3)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle pulse; begins a frame when idle
- `pix_in`  in  24  pixel {R[23:16],G[15:8],B[7:0]}
- `pix_valid`  in  1  `pix_in` valid
- `pix_ready`  out  1  scheduler accepts a pixel this cycle
- `win`  out  216  window {a,b,c,d,e,f,g,h,i}, a in [215:192]; a/b/c top row L→R, e centre
- `ed_en`  out  1  edge detector enable, active low
- `ed_out`  in  1  detector result
- `edge_out`  out  1  edge bit for current interior pixel
- `edge_valid`  out  1  `edge_out` valid, one-cycle pulse
- `busy`  out  1  frame in progress
- `done`  out  1  one-cycle pulse after last result

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN on `start`.
  - RUN→DRAIN after the pixel at (IMG_H-1, IMG_W-1) is accepted.
  - DRAIN→IDLE after the last `edge_valid`, asserting `done` in that same cycle.
- `start` is ignored outside IDLE.
- `pix_ready` = (state==RUN). A pixel is accepted when `pix_valid && pix_ready`. Stalls (`pix_valid` low) freeze all counters and the window.
- Counters: `col` runs 0..IMG_W-1 and wraps to 0 with `row`+1. `row` runs 0..IMG_H-1.
- Line buffers: `lb0` holds row r-1 and `lb1` holds row r-2, each IMG_W×24. On accept: `lb1[col]←lb0[col]`, `lb0[col]←pix_in`.
- Window: on accept, the three columns shift left and the new right column is {lb1[col], lb0[col], pix_in} (top, mid, bottom).
- A window is complete when the accepted pixel has row≥2 and col≥2. Its centre is (row-1, col-1).
- Only interior pixels produce results: (IMG_W-2)*(IMG_H-2) results per frame. Border pixels produce nothing. Stale windows after a column wrap are never flagged complete.
- `busy` = state != IDLE.

## Timing
- Cycle N: complete window accepted.
- Cycle N+1: `win` holds that window and `ed_en`=0. The scheduler samples `ed_out` at the end of this cycle.
- Cycle N+2: `edge_out`=sampled value, `edge_valid`=1.
- Latency from accept to result is 2 cycles. Throughput is 1 result per cycle.
- `ed_en`=1 in every cycle with no new complete window. `win` holds its last value.
- `done` is asserted in the cycle of the final `edge_valid`.
- Reset values: `pix_ready`=0, `win`=0, `ed_en`=1, `edge_out`=0, `edge_valid`=0, `busy`=0, `done`=0, state IDLE, counters 0. Line buffer contents are don't-care.
- Reset mid-frame aborts the frame immediately. No further `edge_valid` or `done` is produced. The next frame requires a new `start`.
- `start` coinciding with the `done` cycle is ignored, because the state is still DRAIN in that cycle.

## Configuration
- Macro: `EDGE_SCHED_STATS_EN`.
- Defined: adds output port `edge_count` [15:0].
  - Cleared to 0 on `start` accepted in IDLE and on reset.
  - Increments by 1 on each `edge_valid && edge_out`, saturating at 16'hFFFF.
  - Holds its value after `done`.
- Undefined: no `edge_count` port and no counter logic. All other behaviour is identical.

## Test plan
- 4×4 frame of constant 24'h808080, bench `ed_out` model returns 0 → exactly 4 `edge_valid` pulses, all `edge_out`=0, `done` coincides with the 4th pulse, then `busy`=0.
- 5×5 frame with pix = row*5+col on all channels → first `win` = {0,1,2,5,6,7,10,11,12} at accept(2,2)+1, `ed_en`=0 for exactly 9 cycles total.
- Same 5×5 frame with `pix_valid` toggled 1,0,1,0 → same 9 windows in the same order; `ed_en` low only the cycle after each completing accept.
- Bench `ed_out`=1 only for centre (2,2) of a 5×5 frame → `edge_out`=1 on the 5th result only; with `EDGE_SCHED_STATS_EN`, `edge_count`=1 after `done`.
- `rst_n` low at row 3 of a 6×6 frame → all outputs return to reset values asynchronously, no `done`. A new `start` then yields 16 results.
- `start` pulsed during RUN → ignored; result count and `done` timing unchanged.
